// File: rtl/ppu_bus_ctrl_pkg.sv
// Shared definitions for the PPU bus controller: register offsets,
// nametable mirroring modes and DMA state encodings.
package ppu_bus_ctrl_pkg;

  localparam logic [2:0] REG_CTRL1   = 3'd0;
  localparam logic [2:0] REG_CTRL2   = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  localparam logic [15:0] REG_OAMDMA = 16'h4014;

  localparam int MIRROR_HORZ   = 0;
  localparam int MIRROR_VERT   = 1;
  localparam int MIRROR_SINGLE = 2;
  localparam int MIRROR_FOUR   = 3;

  localparam logic [13:0] PAL_BASE  = 14'h3F00;
  localparam logic [13:0] NT_BASE   = 14'h2000;
  localparam logic [13:0] PAL_PHYS  = 14'h3000;
  localparam logic [13:0] PAL_TO_NT = 14'h1000;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_ALIGN = 2'd1,
    DMA_RD    = 2'd2,
    DMA_WR    = 2'd3
  } dma_state_t;

  // $2000-$3FFF: the eight PPU registers repeat every 8 bytes.
  function automatic logic is_ppu_reg(input logic [15:0] addr);
    return addr[15:13] == 3'b001;
  endfunction

endpackage

// File: rtl/ppu_bus_ctrl_if.sv
// CPU-side register bus of the PPU bus controller.
interface ppu_bus_ctrl_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic        cpu_stall;

  modport master (
    output cpu_addr, cpu_data_in, cpu_write_en, cpu_read_en,
    input  cpu_data_out, cpu_stall
  );

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_write_en, cpu_read_en,
    output cpu_data_out, cpu_stall
  );

endinterface

// File: rtl/ppu_addr_map.sv
// Folds a 14-bit PPU pointer onto physical VRAM: pattern tables pass through,
// nametables fold by mirroring mode, palette entries land at $3000+.
module ppu_addr_map
  import ppu_bus_ctrl_pkg::*;
#(
  parameter int MIRROR  = 1,
  parameter int VRAM_AW = 14
) (
  input  logic [13:0]        ptr,
  output logic [VRAM_AW-1:0] addr
);

  logic [11:0] nt_off;
  logic [4:0]  pal;
  logic [13:0] phys;

  always_comb begin
    case (MIRROR)
      MIRROR_HORZ:   nt_off = {1'b0, ptr[11], ptr[9:0]};
      MIRROR_VERT:   nt_off = {1'b0, ptr[10], ptr[9:0]};
      MIRROR_SINGLE: nt_off = {2'b00, ptr[9:0]};
      default:       nt_off = ptr[11:0];
    endcase

    // Sprite backdrop entries $3F10/$14/$18/$1C share storage with $3F00/$04/$08/$0C.
    pal = ptr[4:0];
    if (pal[1:0] == 2'b00) pal[4] = 1'b0;

    if (ptr < NT_BASE)       phys = ptr;
    else if (ptr < PAL_BASE) phys = NT_BASE | {2'b00, nt_off};
    else                     phys = PAL_PHYS | {9'd0, pal};
  end

  assign addr = VRAM_AW'(phys);

endmodule

// File: rtl/ppu_bus_ctrl.sv
// CPU-facing PPU register file ($2000-$2007 mirrored, $4014) with VRAM/OAM
// access paths and the 513-cycle sprite DMA engine.
module ppu_bus_ctrl
  import ppu_bus_ctrl_pkg::*;
#(
  parameter int MIRROR  = 1,
  parameter int DMA_EN  = 1,
  parameter int VRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  ppu_bus_ctrl_if.slave      bus,
  output logic [7:0]         ppu_ctrl1,
  output logic [7:0]         ppu_ctrl2,
  input  logic [7:0]         ppu_status,
  output logic               ppu_status_read,
  output logic [7:0]         scroll_x,
  output logic [7:0]         scroll_y,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  input  logic [7:0]         vram_rdata,
  output logic [7:0]         oam_addr,
  output logic [7:0]         oam_wdata,
  output logic               oam_we,
  input  logic [7:0]         oam_rdata,
  output logic [15:0]        dma_addr,
  output logic               dma_rd_en,
  input  logic [7:0]         dma_rdata
);

  dma_state_t  dma_state, dma_state_nxt;
  logic [7:0]  dma_page;
  logic [7:0]  dma_idx;
  logic        dma_rd, dma_wr, dma_start;

  logic [13:0] ptr, fill_ptr, map_ptr, ptr_inc;
  logic        w;
  logic        status_held;
  logic        fill_pend;
  logic [7:0]  rd_buf;

  logic        busy, cpu_wr, cpu_rd, sel_reg;
  logic [2:0]  reg_sel;
  logic        data_acc, status_rd, oam_cpu_we, pal_hit;

  assign busy    = (dma_state != DMA_IDLE);
  assign cpu_wr  = bus.cpu_write_en && !busy;
  assign cpu_rd  = bus.cpu_read_en && !bus.cpu_write_en && !busy;
  assign sel_reg = is_ppu_reg(bus.cpu_addr);
  assign reg_sel = bus.cpu_addr[2:0];

  assign dma_start  = cpu_wr && (bus.cpu_addr == REG_OAMDMA) && (DMA_EN != 0);
  assign data_acc   = sel_reg && (reg_sel == REG_DATA) && (cpu_wr || cpu_rd);
  assign status_rd  = sel_reg && (reg_sel == REG_STATUS) && cpu_rd;
  assign oam_cpu_we = sel_reg && (reg_sel == REG_OAMDATA) && cpu_wr;
  assign pal_hit    = (ptr >= PAL_BASE);
  assign ptr_inc    = ppu_ctrl1[2] ? 14'd32 : 14'd1;

  // DMA state register
  always_ff @(posedge clk) begin
    if (rst) dma_state <= DMA_IDLE;
    else     dma_state <= dma_state_nxt;
  end

  always_comb begin
    dma_state_nxt = dma_state;
    dma_rd        = 1'b0;
    dma_wr        = 1'b0;
    case (dma_state)
      DMA_IDLE:  if (dma_start) dma_state_nxt = DMA_ALIGN;
      DMA_ALIGN: dma_state_nxt = DMA_RD;
      DMA_RD: begin
        dma_rd        = 1'b1;
        dma_state_nxt = DMA_WR;
      end
      DMA_WR: begin
        dma_wr        = 1'b1;
        dma_state_nxt = (dma_idx == 8'hFF) ? DMA_IDLE : DMA_RD;
      end
    endcase
  end

  // Strobes drop in the reset cycle itself so nothing leaks out while aborting.
  assign bus.cpu_stall = busy && !rst;
  assign dma_rd_en     = dma_rd && !rst;
  assign dma_addr      = {dma_page, dma_idx};
  assign oam_we        = (oam_cpu_we || dma_wr) && !rst;
  assign oam_wdata     = dma_wr ? dma_rdata : bus.cpu_data_in;
  assign vram_we       = data_acc && cpu_wr && !rst;
  assign vram_wdata    = bus.cpu_data_in;

  // A pending palette-shadow fill borrows the VRAM port when no $2007 access needs it.
  assign map_ptr = (fill_pend && !data_acc) ? fill_ptr : ptr;

  ppu_addr_map #(
    .MIRROR  (MIRROR),
    .VRAM_AW (VRAM_AW)
  ) u_addr_map (
    .ptr  (map_ptr),
    .addr (vram_addr)
  );

  always_comb begin
    bus.cpu_data_out = 8'h00;
    if (cpu_rd && sel_reg) begin
      case (reg_sel)
        REG_STATUS:  bus.cpu_data_out = ppu_status;
        REG_OAMDATA: bus.cpu_data_out = oam_rdata;
        REG_DATA:    bus.cpu_data_out = pal_hit ? vram_rdata : rd_buf;
        default:     bus.cpu_data_out = 8'h00;
      endcase
    end
  end

  // Register file and pointer state
  always_ff @(posedge clk) begin
    if (rst) begin
      ppu_ctrl1       <= 8'h00;
      ppu_ctrl2       <= 8'h00;
      scroll_x        <= 8'h00;
      scroll_y        <= 8'h00;
      oam_addr        <= 8'h00;
      ppu_status_read <= 1'b0;
      status_held     <= 1'b0;
      ptr             <= 14'h0000;
      w               <= 1'b0;
      rd_buf          <= 8'h00;
      fill_pend       <= 1'b0;
      dma_idx         <= 8'h00;
    end else begin
      status_held     <= status_rd;
      ppu_status_read <= status_rd && !status_held;
      if (status_rd) w <= 1'b0;

      if (cpu_wr && sel_reg) begin
        case (reg_sel)
          REG_CTRL1:   ppu_ctrl1 <= bus.cpu_data_in;
          REG_CTRL2:   ppu_ctrl2 <= bus.cpu_data_in;
          REG_OAMADDR: oam_addr  <= bus.cpu_data_in;
          REG_SCROLL: begin
            if (!w) scroll_x <= bus.cpu_data_in;
            else    scroll_y <= bus.cpu_data_in;
            w <= !w;
          end
          REG_ADDR: begin
            if (!w) ptr[13:8] <= bus.cpu_data_in[5:0];
            else    ptr[7:0]  <= bus.cpu_data_in;
            w <= !w;
          end
          default: ;
        endcase
      end

      if (oam_cpu_we || dma_wr) oam_addr <= oam_addr + 8'd1;

      if (dma_start)   dma_idx <= 8'h00;
      else if (dma_wr) dma_idx <= dma_idx + 8'd1;

      // A fresh $2007 access supersedes any fill still waiting for the port.
      if (data_acc) begin
        ptr       <= ptr + ptr_inc;
        fill_pend <= cpu_rd && pal_hit;
        if (cpu_rd && !pal_hit) rd_buf <= vram_rdata;
      end else if (fill_pend) begin
        rd_buf    <= vram_rdata;
        fill_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dma_start) dma_page <= bus.cpu_data_in;
    if (data_acc && cpu_rd && pal_hit) fill_ptr <= ptr - PAL_TO_NT;
  end

endmodule

// File: tb/tb_ppu_bus_ctrl.sv
// Directed bench for ppu_bus_ctrl: address-map vector table plus CPU access sequences.
module tb_ppu_bus_ctrl;
  import ppu_bus_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ppu_bus_ctrl_if bus ();

  logic [7:0]  ppu_ctrl1, ppu_ctrl2, ppu_status, scroll_x, scroll_y;
  logic        ppu_status_read, vram_we, oam_we, dma_rd_en;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata, oam_addr, oam_wdata, oam_rdata, dma_rdata;
  logic [15:0] dma_addr;

  ppu_bus_ctrl #(.MIRROR(0), .DMA_EN(1), .VRAM_AW(14)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .ppu_ctrl1       (ppu_ctrl1),
    .ppu_ctrl2       (ppu_ctrl2),
    .ppu_status      (ppu_status),
    .ppu_status_read (ppu_status_read),
    .scroll_x        (scroll_x),
    .scroll_y        (scroll_y),
    .vram_addr       (vram_addr),
    .vram_wdata      (vram_wdata),
    .vram_we         (vram_we),
    .vram_rdata      (vram_rdata),
    .oam_addr        (oam_addr),
    .oam_wdata       (oam_wdata),
    .oam_we          (oam_we),
    .oam_rdata       (oam_rdata),
    .dma_addr        (dma_addr),
    .dma_rd_en       (dma_rd_en),
    .dma_rdata       (dma_rdata)
  );

  // Stand-alone address maps, one per mirroring mode
  logic [13:0] map_ptr, m_h, m_v, m_s, m_f;
  ppu_addr_map #(.MIRROR(0), .VRAM_AW(14)) u_map_h (.ptr(map_ptr), .addr(m_h));
  ppu_addr_map #(.MIRROR(1), .VRAM_AW(14)) u_map_v (.ptr(map_ptr), .addr(m_v));
  ppu_addr_map #(.MIRROR(2), .VRAM_AW(14)) u_map_s (.ptr(map_ptr), .addr(m_s));
  ppu_addr_map #(.MIRROR(3), .VRAM_AW(14)) u_map_f (.ptr(map_ptr), .addr(m_f));

  // Memory models around the DUT
  logic [7:0]  vmem [0:16383];
  logic [7:0]  omem [0:255];
  logic [13:0] last_waddr;
  logic [7:0]  last_wdata;
  int          stall_cnt = 0;
  int          pulse_cnt = 0;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign vram_rdata = vmem[vram_addr];
  assign oam_rdata  = omem[oam_addr];

  always @(posedge clk) begin
    if (vram_we) begin
      vmem[vram_addr] <= vram_wdata;
      last_waddr      <= vram_addr;
      last_wdata      <= vram_wdata;
    end
    if (oam_we)    omem[oam_addr] <= oam_wdata;
    if (dma_rd_en) dma_rdata      <= src_byte(dma_addr);
  end

  always @(negedge clk) begin
    if (bus.cpu_stall)   stall_cnt++;
    if (ppu_status_read) pulse_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_addr     = a;
    bus.cpu_data_in  = d;
    bus.cpu_write_en = 1'b1;
    @(negedge clk);
    bus.cpu_write_en = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.cpu_addr    = a;
    bus.cpu_read_en = 1'b1;
    #1 d = bus.cpu_data_out;
    @(negedge clk);
    bus.cpu_read_en = 1'b0;
  endtask

  task automatic set_ptr(input logic [7:0] hi, input logic [7:0] lo);
    cpu_wr(16'h2006, hi);
    cpu_wr(16'h2006, lo);
  endtask

  task automatic wait_dma_done(input int budget);
    int n = 0;
    while (bus.cpu_stall && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("dma_done_in_budget", 16'(bus.cpu_stall), 16'd0);
  endtask

  typedef struct packed {
    logic [13:0] ptr;
    logic [13:0] e_h;
    logic [13:0] e_v;
    logic [13:0] e_s;
    logic [13:0] e_f;
  } map_vec_t;

  map_vec_t mv [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int base;

    mv[0]  = '{14'h0123, 14'h0123, 14'h0123, 14'h0123, 14'h0123};
    mv[1]  = '{14'h1FFF, 14'h1FFF, 14'h1FFF, 14'h1FFF, 14'h1FFF};
    mv[2]  = '{14'h2000, 14'h2000, 14'h2000, 14'h2000, 14'h2000};
    mv[3]  = '{14'h2400, 14'h2000, 14'h2400, 14'h2000, 14'h2400};
    mv[4]  = '{14'h2800, 14'h2400, 14'h2000, 14'h2000, 14'h2800};
    mv[5]  = '{14'h2C05, 14'h2405, 14'h2405, 14'h2005, 14'h2C05};
    mv[6]  = '{14'h3123, 14'h2123, 14'h2123, 14'h2123, 14'h2123};
    mv[7]  = '{14'h3EFF, 14'h26FF, 14'h26FF, 14'h22FF, 14'h2EFF};
    mv[8]  = '{14'h3F00, 14'h3000, 14'h3000, 14'h3000, 14'h3000};
    mv[9]  = '{14'h3F10, 14'h3000, 14'h3000, 14'h3000, 14'h3000};
    mv[10] = '{14'h3F1D, 14'h301D, 14'h301D, 14'h301D, 14'h301D};
    mv[11] = '{14'h3F14, 14'h3004, 14'h3004, 14'h3004, 14'h3004};
    mv[12] = '{14'h3FE5, 14'h3005, 14'h3005, 14'h3005, 14'h3005};
    mv[13] = '{14'h3F3C, 14'h300C, 14'h300C, 14'h300C, 14'h300C};

    bus.cpu_addr     = 16'h0000;
    bus.cpu_data_in  = 8'h00;
    bus.cpu_write_en = 1'b0;
    bus.cpu_read_en  = 1'b0;
    ppu_status       = 8'hA5;
    map_ptr          = 14'h0000;
    rst              = 1'b1;

    for (int i = 0; i < 14; i++) begin
      map_ptr = mv[i].ptr;
      #1;
      check($sformatf("map_h[%h]", mv[i].ptr), 16'(m_h), 16'(mv[i].e_h));
      check($sformatf("map_v[%h]", mv[i].ptr), 16'(m_v), 16'(mv[i].e_v));
      check($sformatf("map_s[%h]", mv[i].ptr), 16'(m_s), 16'(mv[i].e_s));
      check($sformatf("map_f[%h]", mv[i].ptr), 16'(m_f), 16'(mv[i].e_f));
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl1", 16'(ppu_ctrl1), 16'h00);
    check("rst_ctrl2", 16'(ppu_ctrl2), 16'h00);
    check("rst_scroll_x", 16'(scroll_x), 16'h00);
    check("rst_scroll_y", 16'(scroll_y), 16'h00);
    check("rst_oam_addr", 16'(oam_addr), 16'h00);
    check("rst_stall", 16'(bus.cpu_stall), 16'h0);
    check("rst_status_read", 16'(ppu_status_read), 16'h0);
    rst = 1'b0;

    // $2006 pointer load (second byte via a mirror) and $2007 writes
    cpu_wr(16'h2006, 8'h21);
    cpu_wr(16'h3FF6, 8'h08);
    cpu_wr(16'h2007, 8'hAA);
    check("w2007_addr", 16'(last_waddr), 16'h2108);
    check("w2007_data", 16'(last_wdata), 16'h00AA);
    cpu_wr(16'h2007, 8'hBB);
    check("w2007_ptr_inc1", 16'(last_waddr), 16'h2109);

    // Scroll with the shared toggle cleared by a $2002 read
    base = pulse_cnt;
    cpu_wr(16'h2005, 8'h10);
    cpu_rd(16'h2002, rd);
    check("status_rd_data", 16'(rd), 16'h00A5);
    cpu_wr(16'h2005, 8'h20);
    check("scroll_x_after_clear", 16'(scroll_x), 16'h0020);
    check("scroll_y_untouched", 16'(scroll_y), 16'h0000);
    check("status_pulse_once", 16'(pulse_cnt - base), 16'd1);
    cpu_wr(16'h2005, 8'h33);
    check("scroll_y_second", 16'(scroll_y), 16'h0033);
    check("scroll_x_kept", 16'(scroll_x), 16'h0020);

    base = pulse_cnt;
    @(negedge clk);
    bus.cpu_addr    = 16'h2002;
    bus.cpu_read_en = 1'b1;
    repeat (3) @(negedge clk);
    bus.cpu_read_en = 1'b0;
    repeat (2) @(negedge clk);
    check("status_pulse_held", 16'(pulse_cnt - base), 16'd1);

    // Horizontal mirroring, buffered reads and palette direct reads
    set_ptr(8'h24, 8'h00);
    cpu_wr(16'h2007, 8'h55);
    check("nt_fold_2400", 16'(last_waddr), 16'h2000);
    set_ptr(8'h2F, 8'h00);
    cpu_wr(16'h2007, 8'h77);
    check("nt_fold_2f00", 16'(last_waddr), 16'h2700);
    set_ptr(8'h20, 8'h00);
    cpu_rd(16'h2007, rd);
    check("rd_buf_after_reset", 16'(rd), 16'h0000);
    cpu_rd(16'h2007, rd);
    check("rd_2000_mirror", 16'(rd), 16'h0055);
    set_ptr(8'h3F, 8'h10);
    cpu_wr(16'h2007, 8'h2A);
    check("pal_alias_w", 16'(last_waddr), 16'h3000);
    set_ptr(8'h3F, 8'h00);
    cpu_rd(16'h2007, rd);
    check("pal_direct_rd", 16'(rd), 16'h002A);
    set_ptr(8'h20, 8'h00);
    cpu_rd(16'h2007, rd);
    check("pal_shadow_fill", 16'(rd), 16'h0077);

    // Increment by 32
    set_ptr(8'h20, 8'h00);
    cpu_wr(16'h2007, 8'hC3);
    cpu_wr(16'h2000, 8'h04);
    check("ctrl1_write", 16'(ppu_ctrl1), 16'h0004);
    cpu_rd(16'h2000, rd);
    check("wo_reg_reads_zero", 16'(rd), 16'h0000);
    cpu_rd(16'h4014, rd);
    check("dma_reg_reads_zero", 16'(rd), 16'h0000);
    set_ptr(8'h20, 8'h00);
    cpu_rd(16'h2007, rd);
    check("inc32_stale_buf", 16'(rd), 16'h0055);
    cpu_rd(16'h2007, rd);
    check("inc32_mem_2000", 16'(rd), 16'h00C3);
    cpu_wr(16'h2007, 8'hE1);
    check("inc32_ptr_2040", 16'(last_waddr), 16'h2040);
    set_ptr(8'hFF, 8'hF0);
    cpu_wr(16'h2007, 8'h0D);
    check("ptr_hi_masked", 16'(last_waddr), 16'h3000);
    cpu_wr(16'h2007, 8'h0E);
    check("ptr_wrap", 16'(last_waddr), 16'h0010);
    cpu_wr(16'h2000, 8'h00);

    // OAM port, ctrl2 via mirror, unmapped address
    cpu_wr(16'h2003, 8'h11);
    cpu_wr(16'h2004, 8'h4B);
    cpu_wr(16'h2003, 8'h10);
    cpu_wr(16'h2004, 8'h9A);
    check("oam_addr_inc", 16'(oam_addr), 16'h0011);
    check("oam_write_data", 16'(omem[8'h10]), 16'h009A);
    cpu_rd(16'h2004, rd);
    check("oam_read_data", 16'(rd), 16'h004B);
    check("oam_read_no_inc", 16'(oam_addr), 16'h0011);
    cpu_wr(16'h2009, 8'h1E);
    check("ctrl2_mirror", 16'(ppu_ctrl2), 16'h001E);
    cpu_wr(16'h4000, 8'h55);
    check("unmapped_ignored", 16'(ppu_ctrl1), 16'h0000);

    // Sprite DMA from page $02 starting at OAM $FE
    base = stall_cnt;
    cpu_wr(16'h2003, 8'hFE);
    cpu_wr(16'h4014, 8'h02);
    check("dma_stall_up", 16'(bus.cpu_stall), 16'h1);
    cpu_wr(16'h2000, 8'hFF);
    cpu_wr(16'h4014, 8'h07);
    wait_dma_done(2000);
    check("dma_stall_cycles", 16'(stall_cnt - base), 16'd513);
    check("dma_oam_fe", 16'(omem[8'hFE]), 16'h0058);
    check("dma_oam_fd", 16'(omem[8'hFD]), 16'h00A7);
    check("dma_oam_00", 16'(omem[8'h00]), 16'h005A);
    check("dma_oam_addr_end", 16'(oam_addr), 16'h00FE);
    check("dma_cpu_wr_ignored", 16'(ppu_ctrl1), 16'h0000);
    repeat (2) @(negedge clk);
    check("dma_retrigger_ignored", 16'(bus.cpu_stall), 16'h0);

    // Reset in the middle of a DMA
    cpu_wr(16'h2000, 8'h81);
    cpu_wr(16'h2005, 8'h12);
    cpu_wr(16'h4014, 8'h03);
    repeat (99) @(negedge clk);
    check("dma_busy_before_rst", 16'(bus.cpu_stall), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_stall", 16'(bus.cpu_stall), 16'h0);
    check("abort_oam_we", 16'(oam_we), 16'h0);
    check("abort_dma_rd", 16'(dma_rd_en), 16'h0);
    check("abort_vram_we", 16'(vram_we), 16'h0);
    check("abort_ctrl1", 16'(ppu_ctrl1), 16'h0000);
    check("abort_ctrl2", 16'(ppu_ctrl2), 16'h0000);
    check("abort_scroll", 16'({scroll_x, scroll_y}), 16'h0000);
    check("abort_oam_addr", 16'(oam_addr), 16'h0000);
    cpu_rd(16'h2007, rd);
    check("abort_buf_cleared", 16'(rd), 16'h0000);
    cpu_wr(16'h2005, 8'h44);
    check("abort_w_cleared", 16'(scroll_x), 16'h0044);
    check("abort_w_cleared_y", 16'(scroll_y), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
